// File: rtl/multibyte_arith_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multibyte_arith_sequencer_pkg                              |
// | Purpose : Shared constants for the multibyte arithmetic sequencer:   |
// |           byte width, op_code encodings and the FSM state type.      |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package multibyte_arith_sequencer_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUB2 = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_DEC  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/multibyte_arith_sequencer_byte_adder_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : byte_adder_unit                                            |
// | Purpose : Combinational 8-bit adder with carry in and carry out.     |
// | Ports   : a_i     - A operand byte                                   |
// |           b_i     - B' operand byte                                  |
// |           c_i     - carry in                                         |
// |           sum_o   - sum byte                                         |
// |           carry_o - carry out (9th bit of the sum)                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module byte_adder_unit
  import multibyte_arith_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              c_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              carry_o
);

  logic [BYTE_W:0] w_full;

  assign w_full  = {1'b0, a_i} + {1'b0, b_i} + {{BYTE_W{1'b0}}, c_i};
  assign sum_o   = w_full[BYTE_W-1:0];
  assign carry_o = w_full[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/multibyte_arith_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multibyte_arith_sequencer                                  |
// | Purpose : Byte-serial wide arithmetic unit. A request is captured in |
// |           IDLE, one byte is processed per cycle LSB first in RUN,    |
// |           and the registered result is presented in DONE until the   |
// |           consumer accepts it.                                       |
// | Ports   : clk, rst                  - clock, sync active-high reset  |
// |           start_valid/start_ready   - request handshake              |
// |           op_code, a_in, b_in       - operation and operands         |
// |           carry_in                  - carry for add-with-carry       |
// |           result_valid/result_ready - result handshake               |
// |           result_out, carry_out     - wide result, final carry       |
// |           zero_flag                 - result_out is all zeros        |
// |           busy                      - operation in progress          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module multibyte_arith_sequencer
  import multibyte_arith_sequencer_pkg::*;
#(
  parameter int NUM_BYTES    = 4,
  parameter int op_code_size = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [op_code_size-1:0]     op_code,
  input  logic [8*NUM_BYTES-1:0]      a_in,
  input  logic [8*NUM_BYTES-1:0]      b_in,
  input  logic                        carry_in,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [8*NUM_BYTES-1:0]      result_out,
  output logic                        carry_out,
  output logic                        zero_flag,
  output logic                        busy
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     bp_q, bp_d;
  logic [W-1:0]     res_q, res_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic [W-1:0]      w_bsel;
  logic              w_c0;
  logic [BYTE_W-1:0] w_sum;
  logic              w_carry;

  // The operand registers shift right each RUN cycle so the adder always
  // sees the current byte in the low lane; the result shifts in from the
  // top so that after NUM_BYTES steps every byte sits in its own lane.
  byte_adder_unit u_byte_adder (
    .a_i     (a_q[BYTE_W-1:0]),
    .b_i     (bp_q[BYTE_W-1:0]),
    .c_i     (c_q),
    .sum_o   (w_sum),
    .carry_o (w_carry)
  );

  // B' and initial carry chosen from the incoming op_code at capture time,
  // so later op_code changes cannot influence the running operation.
  always_comb begin
    w_bsel = '0;
    w_c0   = 1'b0;
    case (op_code[2:0])
      OP_ADD:          begin w_bsel = b_in;  w_c0 = 1'b0;     end
      OP_ADC:          begin w_bsel = b_in;  w_c0 = carry_in; end
      OP_SUB, OP_SUB2: begin w_bsel = ~b_in; w_c0 = 1'b1;     end
      OP_INC:          begin w_bsel = '0;    w_c0 = 1'b1;     end
      OP_DEC:          begin w_bsel = '1;    w_c0 = 1'b0;     end
      default:         begin w_bsel = '0;    w_c0 = 1'b0;     end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    bp_d         = bp_q;
    res_d        = res_q;
    c_d          = c_q;
    cout_d       = cout_q;
    zero_d       = zero_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = a_in;
          bp_d    = w_bsel;
          c_d     = w_c0;
          idx_d   = '0;
          cout_d  = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        a_d   = a_q >> BYTE_W;
        bp_d  = bp_q >> BYTE_W;
        res_d = {w_sum, res_q[W-1:BYTE_W]};
        c_d   = w_carry;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
          // Flags are latched from the completed result so they stay
          // registered and aligned with result_out throughout DONE.
          cout_d  = w_carry;
          zero_d  = (res_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      bp_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      bp_q    <= bp_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign result_out = res_q;
  assign carry_out  = cout_q;
  assign zero_flag  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_multibyte_arith_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multibyte_arith_sequencer                               |
// | Purpose : Scoreboard bench for multibyte_arith_sequencer: directed   |
// |           corner cases plus randomized operations, compared against  |
// |           a plain-arithmetic reference model.                        |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_multibyte_arith_sequencer;
  import multibyte_arith_sequencer_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [2:0]    op_code = '0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          carry_in = 1'b0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [W-1:0]  result_out;
  logic          carry_out;
  logic          zero_flag;
  logic          busy;

  multibyte_arith_sequencer #(.NUM_BYTES(NB), .op_code_size(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_code      (op_code),
    .a_in         (a_in),
    .b_in         (b_in),
    .carry_in     (carry_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_out   (result_out),
    .carry_out    (carry_out),
    .zero_flag    (zero_flag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    int           cap;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: straight wide-integer arithmetic on the whole operands.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] maxv;
    maxv = '1;
    case (op)
      3'd1:       full = {1'b0, a} + {1'b0, b};
      3'd2:       full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      3'd3, 3'd4: begin full[W-1:0] = a - b; full[W] = (a >= b);     end
      3'd5:       begin full[W-1:0] = a + 1; full[W] = (a == maxv);  end
      3'd6:       begin full[W-1:0] = a - 1; full[W] = (a != '0);    end
      default:    full = {1'b0, a};
    endcase
    e.res  = full[W-1:0];
    e.cout = full[W];
    e.zero = (full[W-1:0] == '0);
    e.cap  = 0;
    return e;
  endfunction

  // Monitor: checks latency, stability while stalled, and pops the
  // scoreboard on every accepted result.
  logic         prev_v    = 1'b0;
  logic         after_acc = 1'b0;
  logic [W+1:0] snap;

  always @(negedge clk) begin
    if (rst) begin
      prev_v    = 1'b0;
      after_acc = 1'b0;
    end else begin
      if (after_acc) begin
        chk("start_ready_after_accept", {62'd0, start_ready, result_valid}, 64'd2);
        after_acc = 1'b0;
      end
      if (result_valid) begin
        chk("start_ready_in_done", {63'd0, start_ready}, 64'd0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_result: got result 0x%0h expected no result", result_out);
          end else begin
            chk("latency", 64'(cyc - sb[0].cap), 64'(NB));
          end
          snap = {result_out, carry_out, zero_flag};
        end else begin
          chk("stable_while_stalled", 64'({result_out, carry_out, zero_flag}), 64'(snap));
        end
        if (result_ready && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("result_out", 64'(result_out), 64'(e.res));
          chk("carry_out",  {63'd0, carry_out}, {63'd0, e.cout});
          chk("zero_flag",  {63'd0, zero_flag}, {63'd0, e.zero});
          after_acc = 1'b1;
        end
      end
      prev_v = result_valid;
    end
  end

  // One full transaction: wait for IDLE, capture, scramble inputs, then
  // stall the result for 'hold' cycles, optionally poking start_valid.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold, input bit poke);
    int   n;
    exp_t e;
    n = 0;
    while (!start_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!start_ready) begin
      chk("start_ready_timeout", 64'd0, 64'd1);
      return;
    end
    op_code = op; a_in = a; b_in = b; carry_in = cin; start_valid = 1'b1;
    @(posedge clk); #1;
    e     = model(op, a, b, cin);
    e.cap = cyc;
    sb.push_back(e);
    start_valid = 1'b0;
    op_code  = 3'($urandom);
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    carry_in = 1'($urandom);
    chk("busy_in_run", {63'd0, busy}, 64'd1);
    n = 0;
    while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!result_valid) begin
      chk("result_valid_timeout", 64'd0, 64'd1);
      void'(sb.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 2) start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 9));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state",
        {25'd0, start_ready, result_valid, busy, carry_out, zero_flag, result_out},
        {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});

    run_op(OP_ADD,  32'h0000FFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(OP_SUB,  32'h00000005, 32'h00000007, 1'b0, 1, 1'b0);
    run_op(OP_SUB2, 32'h00000007, 32'h00000005, 1'b0, 0, 1'b0);
    run_op(OP_INC,  32'hFFFFFFFF, 32'h12345678, 1'b0, 0, 1'b0);
    run_op(OP_DEC,  32'h00000000, 32'h12345678, 1'b1, 2, 1'b0);
    run_op(OP_ADC,  32'h000000FF, 32'h00000000, 1'b1, 5, 1'b1);
    run_op(OP_PASS, 32'hA5A5_0000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    run_op(3'b111,  32'h0000_0000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);

    // Abort in the second RUN cycle: no result may ever appear.
    while (!start_ready) begin @(posedge clk); #1; end
    op_code = OP_ADD; a_in = 32'h1234_5678; b_in = 32'h1111_1111; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state",
        {25'd0, start_ready, result_valid, busy, carry_out, zero_flag, result_out},
        {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    repeat (3 * NB) @(posedge clk);
    #1;

    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom), rnd_operand(), rnd_operand(), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2 * NB) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
